// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARMv4 control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit.sv
// ARMv4 condition evaluation: Cond field against the {N,Z,C,V} flag register.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;  // 1111 never executes
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARMv4 control unit: sequencing FSM, ALU decode, condition latch and NZCV register.
module multicycle_ctrl_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int NFLAGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic [NFLAGS-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUControl,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic              RegWrite,
    output logic [1:0]        RegSrc,
    output state_t            state_dbg_o,
    output logic [NFLAGS-1:0] flags_dbg_o
);

    state_t            state_q, state_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              cond_ex_q, cond_ex_d;
    logic              cond_ex;

    logic       is_cmp, flag_cmd, cv_cmd;
    logic [1:0] alu_dp;
    logic       regw, memw, branch, irw, pcw_fetch;

    cond_unit u_cond (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign is_cmp = (Funct[4:1] == CMD_CMP);

    // Unrecognised commands fall back to ADD and never touch the flags.
    always_comb begin
        alu_dp   = ALU_ADD;
        flag_cmd = 1'b0;
        cv_cmd   = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin alu_dp = ALU_ADD; flag_cmd = 1'b1; cv_cmd = 1'b1; end
            CMD_SUB: begin alu_dp = ALU_SUB; flag_cmd = 1'b1; cv_cmd = 1'b1; end
            CMD_CMP: begin alu_dp = ALU_SUB; flag_cmd = 1'b1; cv_cmd = 1'b1; end
            CMD_AND: begin alu_dp = ALU_AND; flag_cmd = 1'b1; end
            CMD_ORR: begin alu_dp = ALU_ORR; flag_cmd = 1'b1; end
            default: begin alu_dp = ALU_ADD; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cond_ex_d  = cond_ex_q;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        irw        = 1'b0;
        pcw_fetch  = 1'b0;
        case (state_q)
            FETCH: begin
                irw       = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_fetch = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                cond_ex_d = cond_ex;
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                AdrSrc    = 1'b1;  // address held stable through the load writeback
                ResultSrc = 2'b01;
                regw      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                memw    = 1'b1;
                state_d = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dp;
                state_d    = ALUWB;
                if (cond_ex_q && flag_cmd && (Funct[0] || is_cmp)) begin
                    flags_d[FLAG_N] = ALUFlags[FLAG_N];
                    flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
                    if (cv_cmd) begin
                        flags_d[FLAG_C] = ALUFlags[FLAG_C];
                        flags_d[FLAG_V] = ALUFlags[FLAG_V];
                    end
                end
            end
            ALUWB: begin
                regw    = ~is_cmp;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign ImmSrc   = Op;
    assign RegSrc   = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
    assign RegWrite = ~reset & regw & cond_ex_q;
    assign MemWrite = ~reset & memw & cond_ex_q;
    assign IRWrite  = ~reset & irw;
    assign PCWrite  = ~reset & (pcw_fetch | (cond_ex_q & (branch | (regw & (Rd == 4'd15)))));

    assign state_dbg_o = state_q;
    assign flags_dbg_o = flags_q;

endmodule
